// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler
// Column-scan scheduler and double-buffered frame store for an 8x8 LED matrix.
// The matrix is driven one column at a time; each column slot starts with a
// blanking interval and then shows the column's row data from the front
// buffer. Producers write into the back buffer and request a swap with
// `commit`; the swap happens only at a frame boundary.
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   CE           one-cycle tick enable; all scan timing advances only on CE
//   wr_en        write request into the back buffer
//   wr_addr      column index to write (0..7)
//   wr_data      row bits for that column (bit r -> rows[r])
//   commit       request a back-to-front swap at the next frame boundary
//   wr_ready     write/commit accepted this cycle (= !swap_pending)
//   swap_pending commit accepted, swap not yet performed
//   frame_start  one-cycle pulse in the first cycle of each new frame
//   cols         one-hot column select, registered (inverted if COL_ACTIVE_LOW)
//   rows         row data of the active column, registered
module matrix_frame_scheduler #(
    parameter int unsigned COL_TICKS      = 125,
    parameter int unsigned BLANK_TICKS    = 2,
    parameter bit          COL_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       wr_ready,
    output logic       swap_pending,
    output logic       frame_start,
    output logic [7:0] cols,
    output logic [7:0] rows
);

    localparam int unsigned TW = $clog2(COL_TICKS);
    localparam logic [TW-1:0] TICK_LAST  = TW'(COL_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [7:0]    COL_OFF    = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    phase_t        phase, phase_n;
    logic [2:0]    col_idx, col_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic          front;
    logic          boundary;
    logic [7:0]    cols_n, rows_n;
    logic [7:0]    bank [2][8];

    assign wr_ready = ~swap_pending;

    // Next scan position; the output registers are loaded from the next
    // position so cols/rows change in the cycle right after the CE edge.
    always_comb begin
        phase_n  = phase;
        col_n    = col_idx;
        tick_n   = tick_cnt;
        boundary = 1'b0;
        if (CE) begin
            if (tick_cnt == TICK_LAST) begin
                tick_n   = '0;
                phase_n  = BLANK;
                col_n    = col_idx + 3'd1;
                boundary = (col_idx == 3'd7);
            end else begin
                tick_n = tick_cnt + TW'(1);
                if (tick_cnt == BLANK_LAST) begin
                    phase_n = SHOW;
                end
            end
        end
    end

    // Front only toggles on a boundary, whose next phase is BLANK, so the
    // current front is always the right source for a SHOW slot.
    always_comb begin
        cols_n = COL_OFF;
        rows_n = '0;
        if (phase_n == SHOW) begin
            cols_n = (8'h01 << col_n) ^ COL_OFF;
            rows_n = bank[front][col_n];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase        <= BLANK;
            col_idx      <= '0;
            tick_cnt     <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            frame_start  <= 1'b0;
            cols         <= COL_OFF;
            rows         <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned c = 0; c < 8; c++) begin
                    bank[b][c] <= '0;
                end
            end
        end else begin
            phase       <= phase_n;
            col_idx     <= col_n;
            tick_cnt    <= tick_n;
            cols        <= cols_n;
            rows        <= rows_n;
            frame_start <= boundary;

            if (wr_en && !swap_pending) begin
                bank[~front][wr_addr] <= wr_data;
            end

            // A commit can only be accepted while nothing is pending, so it
            // never collides with the swap itself.
            if (boundary && swap_pending) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end else if (commit && !swap_pending) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler
// Scoreboard bench for matrix_frame_scheduler. Unit A runs with CE tied high
// and active-high columns; unit B shares reset, gets CE every third clock and
// uses active-low columns. Stimulus pushes the expected outputs of each cycle
// into a queue; a negedge monitor pops and compares.
module tb_matrix_frame_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE = 1'b1;
    logic       ce2 = 1'b0;
    logic       wr_en = 1'b0;
    logic       commit = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       nil = 1'b0;
    logic [2:0] nil3 = '0;
    logic [7:0] nil8 = '0;

    logic       a_rdy, a_pend, a_fs;
    logic [7:0] a_cols, a_rows;
    logic       b_rdy, b_pend, b_fs;
    logic [7:0] b_cols, b_rows;

    always #5 CLK = ~CLK;

    matrix_frame_scheduler #(
        .COL_TICKS(4), .BLANK_TICKS(1), .COL_ACTIVE_LOW(1'b0)
    ) dut_a (
        .CLK(CLK), .RST(RST), .CE(CE),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .wr_ready(a_rdy), .swap_pending(a_pend), .frame_start(a_fs),
        .cols(a_cols), .rows(a_rows)
    );

    matrix_frame_scheduler #(
        .COL_TICKS(4), .BLANK_TICKS(1), .COL_ACTIVE_LOW(1'b1)
    ) dut_b (
        .CLK(CLK), .RST(RST), .CE(ce2),
        .wr_en(nil), .wr_addr(nil3), .wr_data(nil8), .commit(nil),
        .wr_ready(b_rdy), .swap_pending(b_pend), .frame_start(b_fs),
        .cols(b_cols), .rows(b_rows)
    );

    typedef struct {
        int unsigned tag;
        int unsigned which;
        int unsigned k;
        logic [7:0]  cols;
        logic [7:0]  rows;
        logic        fs;
        logic        rdy;
    } exp_t;

    exp_t        sb[$];
    int unsigned gc = 0;
    int unsigned k = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic        exp_rdy = 1'b1;
    logic [7:0]  disp [8];

    always @(posedge CLK) gc <= gc + 1;

    // Column select for scan position pos (CE ticks since reset), slot of
    // 4 ticks with 1 blank tick first, 8 columns per frame.
    function automatic logic [7:0] scan_cols(input int unsigned pos);
        int unsigned p;
        logic [7:0] one;
        p = pos % 32;
        one = 8'h01;
        if (p % 4 == 0) return 8'h00;
        return one << (p / 4);
    endfunction

    task automatic run_cycle();
        logic rs;
        int unsigned p, c;
        exp_t e;
        rs = RST;
        @(posedge CLK);
        #1;
        wr_en  = 1'b0;
        commit = 1'b0;
        if (rs) k = 0; else k = k + 1;

        p = k % 32;
        e.tag = gc; e.which = 0; e.k = k;
        if (rs) begin
            e.cols = 8'h00; e.rows = 8'h00; e.fs = 1'b0; e.rdy = 1'b1;
        end else begin
            e.cols = scan_cols(k);
            e.rows = (p % 4 == 0) ? 8'h00 : disp[p / 4];
            e.fs   = (k > 0) && (p == 0);
            e.rdy  = exp_rdy;
        end
        sb.push_back(e);

        c = k / 3;
        p = c % 32;
        e.which = 1;
        e.rows  = 8'h00;
        e.rdy   = 1'b1;
        if (rs) begin
            e.cols = 8'hFF; e.fs = 1'b0;
        end else begin
            e.cols = ~scan_cols(c);
            e.fs   = (k % 3 == 0) && (c > 0) && (p == 0);
        end
        sb.push_back(e);

        ce2 = (k % 3 == 2);
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].tag <= gc) begin
            exp_t e;
            logic [19:0] got, want;
            e = sb.pop_front();
            if (e.which == 0) got = {a_cols, a_rows, a_fs, a_rdy, a_pend, 1'b0};
            else              got = {b_cols, b_rows, b_fs, b_rdy, b_pend, 1'b0};
            want = {e.cols, e.rows, e.fs, e.rdy, ~e.rdy, 1'b0};
            nvec++;
            if (got !== want) begin
                nerr++;
                $display("FAIL scan%0d k=%0d cols/rows/fs/rdy/pend got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         e.which, e.k, got[19:12], got[11:4], got[3], got[2], got[1],
                         want[19:12], want[11:4], want[3], want[2], want[1]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) disp[i] = 8'h00;

        // Reset values, three cycles.
        repeat (3) run_cycle();
        RST = 1'b0;

        // Frame 0 shows zeros; frame 1 shows col2=A5; frame 2 shows col7=3C.
        while (k < 85) begin
            case (k)
                0:  begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5; end
                4:  begin commit = 1'b1; exp_rdy = 1'b0; end
                10: begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF; end
                31: begin exp_rdy = 1'b1; disp[2] = 8'hA5; end
                40: begin
                        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h3C;
                        commit = 1'b1; exp_rdy = 1'b0;
                    end
                63: begin exp_rdy = 1'b1; disp[2] = 8'h00; disp[7] = 8'h3C; end
                64: begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h11; end
                66: begin commit = 1'b1; exp_rdy = 1'b0; end
                default: ;
            endcase
            run_cycle();
        end

        // Reset while col 5 is showing with a swap pending.
        RST = 1'b1;
        exp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) disp[i] = 8'h00;
        repeat (2) run_cycle();
        RST = 1'b0;

        // Both buffers must be cleared: committing the untouched back buffer
        // still displays zeros in the next frame.
        while (k < 70) begin
            case (k)
                1:  begin commit = 1'b1; exp_rdy = 1'b0; end
                31: exp_rdy = 1'b1;
                default: ;
            endcase
            run_cycle();
        end

        repeat (2) @(negedge CLK);
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
